matrix_mem_port_master: RTL and testbench
=========================================

# matrix_mem_port_master

Initiator-side controller for the single-port matrix memory (registered read, one-cycle read latency, write-enable port). Accepts a command to either load a run of words from an input stream into memory or dump a run of words from memory to an output stream with valid/ready backpressure. It sits between the host/stream side of the multiplier datapath and each matrix memory instance, and is the only driver of that memory's address, write data and write enable.

## Interface

Parameters:
- AW, 4, address width; memory depth is 2^AW.
- DW, 32, data word width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid && cmd_ready.
- cmd_load  in  1  1 = load (stream to memory), 0 = dump (memory to stream).
- cmd_base  in  AW  first memory address.
- cmd_count  in  AW+1  number of words; values above 2^AW are clamped to 2^AW.
- s_valid / s_ready / s_data  in / out / DW  load input stream.
- m_valid / m_ready / m_data  out / in / DW  dump output stream.
- m_last  out  1  qualifies the final word of a dump.
- mem_addr  out  AW  memory address.
- mem_write_data  out  DW  memory write data.
- mem_write_enable  out  1  memory write strobe.
- mem_read_data  in  DW  memory registered read data.
- done  out  1  one-cycle completion pulse.

Clock is named clk; reset is named rst; reset is synchronous and active-high.

## Operation

- States: IDLE, LOAD, READ, FLUSH.
- IDLE: cmd_ready=1. On accept, latch base and clamped count. Count 0 -> stay IDLE, done=1 next cycle, no memory access. Otherwise go to LOAD (cmd_load=1) or READ (cmd_load=0).
- LOAD: s_ready=1. Each s_valid handshake, same cycle: mem_write_enable=1, mem_addr=base+idx, mem_write_data=s_data; idx++. After the count-th handshake -> IDLE with done=1.
- READ: 4-entry output FIFO plus rd_pending flag (read issued last cycle). Issue a read (mem_addr=base+idx, idx++) when idx<count and occupancy+rd_pending <= 2. When rd_pending is set, push mem_read_data into FIFO. All reads issued and rd_pending=0 -> FLUSH.
- FLUSH: drain FIFO; on handshake of the final word -> IDLE with done=1.
- m_valid = FIFO non-empty; m_data = FIFO head; m_last = 1 when head is the count-th word.
- Address arithmetic is modulo 2^AW: base+idx wraps past 2^AW-1 to 0.
- mem_write_enable=0 in all states except on a LOAD handshake. mem_addr=0 when no access.
- Simultaneous FIFO push and pop: occupancy unchanged.
- rst overrides everything, including mid-operation: state IDLE, FIFO and counters cleared, rd_pending=0, no done pulse. While rst is high, mem_write_enable, s_ready, m_valid and done are forced 0.

## Timing

- Reset values: cmd_ready=1 (first cycle after rst deasserts), s_ready=0, m_valid=0, m_last=0, m_data=0, mem_addr=0, mem_write_data=0, mem_write_enable=0, done=0.
- Command accepted at cycle T -> LOAD/READ active at T+1.
- Load: write occurs in the same cycle as the stream handshake. Last handshake at W -> done=1 and cmd_ready=1 at W+1.
- Dump: first read issued T+1; mem_read_data valid T+2; first m_valid T+3. With m_ready held high, one word per cycle.
- Dump completion: last m_valid && m_ready at cycle L -> done=1 and cmd_ready=1 at L+1.
- Count 0: done=1 at T+1.
- A new command may be accepted in the same cycle done is high.

## Test plan

- Load count=16, base=0, s_data=0x100+i, s_valid continuous -> writes to addresses 0..15 on T+1..T+16, done at T+17. Then dump count=16, base=0, m_ready=1 -> m_data 0x100..0x10F on consecutive cycles from T+3, m_last with 0x10F, exactly one done.
- Wrap: load count=4, base=14 -> writes to addresses 14, 15, 0, 1. Dump the same range -> identical data, in the same order.
- Backpressure: dump of 16 words with m_ready pseudo-random (~50%) -> no loss or duplication, order preserved, FIFO never exceeds 4 entries, m_data stable while m_valid && !m_ready.
- Count 0, for both load and dump -> done at T+1, no mem_write_enable, no m_valid.
- Load with gapped s_valid (every third cycle low) -> mem_write_enable only on handshake cycles, with correct address sequence.
- Reset asserted mid-dump after 5 words -> next cycle m_valid=0, cmd_ready=1, no done pulse. A following full dump returns correct data from word 0.

Source files
------------

// File: rtl/matrix_mem_port_master_if.sv
// Bundle of command, load-stream, dump-stream and memory-port signals for matrix_mem_port_master.
// The master modport is the controller's view; slave is the host/memory side.
interface matrix_mem_port_master_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_load;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_count;

  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;

  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_enable;
  logic [DW-1:0] mem_read_data;

  logic          done;

  modport master (
    input  cmd_valid, cmd_load, cmd_base, cmd_count,
    input  s_valid, s_data,
    input  m_ready,
    input  mem_read_data,
    output cmd_ready, s_ready, m_valid, m_data, m_last,
    output mem_addr, mem_write_data, mem_write_enable,
    output done
  );

  modport slave (
    output cmd_valid, cmd_load, cmd_base, cmd_count,
    output s_valid, s_data,
    output m_ready,
    output mem_read_data,
    input  cmd_ready, s_ready, m_valid, m_data, m_last,
    input  mem_addr, mem_write_data, mem_write_enable,
    input  done
  );
endinterface

// File: rtl/matrix_mem_port_master.sv
// Sole driver of one single-port matrix memory: loads a run of words from a stream into it,
// or dumps a run of words from it to a backpressured stream through a 4-entry output FIFO.
module matrix_mem_port_master #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32
) (
  input logic                   clk,
  input logic                   rst,
  matrix_mem_port_master_if.master io_bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StRead, StFlush} state_e;

  localparam logic [AW:0] MaxCount = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CntOne   = {{AW{1'b0}}, 1'b1};

  state_e        r_state;
  logic [AW-1:0] r_base;
  logic [AW:0]   r_count;
  logic [AW:0]   r_idx;
  logic [AW:0]   r_out_idx;
  logic          r_rd_pending;
  logic          r_done;
  logic [DW-1:0] r_fifo [4];
  logic [1:0]    r_wr_ptr;
  logic [1:0]    r_rd_ptr;
  logic [2:0]    r_occ;

  logic          w_cmd_fire;
  logic [AW:0]   w_cmd_count;
  logic [AW-1:0] w_addr;
  logic          w_wr;
  logic          w_issue;
  logic          w_m_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_last_word;
  logic          w_final_pop;

  always_comb begin
    w_cmd_fire  = io_bus.cmd_valid && (r_state == StIdle);
    w_cmd_count = (io_bus.cmd_count > MaxCount) ? MaxCount : io_bus.cmd_count;
    w_addr      = r_base + r_idx[AW-1:0];
    w_wr        = (r_state == StLoad) && io_bus.s_valid && !rst;
    // Cap occupancy plus in-flight read at 2 so a landing read always finds FIFO space.
    w_issue     = (r_state == StRead) && (r_idx < r_count) &&
                  ((r_occ + 3'(r_rd_pending)) <= 3'd2) && !rst;
    w_m_valid   = (r_occ != 3'd0) && !rst;
    w_pop       = w_m_valid && io_bus.m_ready;
    w_push      = r_rd_pending;
    w_last_word = (r_out_idx == (r_count - CntOne));
    w_final_pop = w_pop && w_last_word;
  end

  always_comb begin
    io_bus.cmd_ready        = (r_state == StIdle);
    io_bus.s_ready          = (r_state == StLoad) && !rst;
    io_bus.mem_write_enable = w_wr;
    io_bus.mem_write_data   = w_wr ? io_bus.s_data : '0;
    io_bus.mem_addr         = (w_wr || w_issue) ? w_addr : '0;
    io_bus.m_valid          = w_m_valid;
    io_bus.m_data           = w_m_valid ? r_fifo[r_rd_ptr] : '0;
    io_bus.m_last           = w_m_valid && w_last_word;
    io_bus.done             = r_done && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_base       <= '0;
      r_count      <= '0;
      r_idx        <= '0;
      r_out_idx    <= '0;
      r_rd_pending <= 1'b0;
      r_done       <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
    end else begin
      r_done       <= 1'b0;
      r_rd_pending <= w_issue;

      if (w_push) begin
        r_fifo[r_wr_ptr] <= io_bus.mem_read_data;
        r_wr_ptr         <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 2'd1;
        r_out_idx <= r_out_idx + CntOne;
      end
      r_occ <= r_occ + 3'(w_push) - 3'(w_pop);

      unique case (r_state)
        StIdle: begin
          if (w_cmd_fire) begin
            r_base    <= io_bus.cmd_base;
            r_count   <= w_cmd_count;
            r_idx     <= '0;
            r_out_idx <= '0;
            if (w_cmd_count == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= io_bus.cmd_load ? StLoad : StRead;
            end
          end
        end
        StLoad: begin
          if (io_bus.s_valid) begin
            r_idx <= r_idx + CntOne;
            if (r_idx == (r_count - CntOne)) begin
              r_state <= StIdle;
              r_done  <= 1'b1;
            end
          end
        end
        StRead: begin
          if (w_issue) begin
            r_idx <= r_idx + CntOne;
          end
          // The final word can leave before READ hands over to FLUSH (short dumps).
          if (w_final_pop) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end else if ((r_idx == r_count) && !r_rd_pending) begin
            r_state <= StFlush;
          end
        end
        StFlush: begin
          if (w_final_pop) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mem_port_master.sv
// Directed-random bench for matrix_mem_port_master: behavioural memory, shadow copy of the
// expected memory contents, and per-cycle checks of the load and dump streams.
module tb_matrix_mem_port_master;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int Depth = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_mem_port_master_if #(.AW(AW), .DW(DW)) bus ();

  matrix_mem_port_master #(.AW(AW), .DW(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  // Single-port memory with registered read.
  logic [DW-1:0] mem [Depth];
  always @(posedge clk) begin
    if (bus.mem_write_enable) mem[bus.mem_addr] <= bus.mem_write_data;
    bus.mem_read_data <= mem[bus.mem_addr];
  end

  logic [DW-1:0] ref_mem [Depth];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input bit load, input int base, input int count);
    logic [31:0] b;
    logic [31:0] n;
    b = base;
    n = count;
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = load;
    bus.cmd_base  = b[AW-1:0];
    bus.cmd_count = n[AW:0];
    bus.s_valid   = 1'b0;
    bus.m_ready   = 1'b0;
    #1;
    chk("cmd_ready", bus.cmd_ready, 1);
  endtask

  task automatic do_load(input int base, input int count, input bit gapped, input bit pattern);
    int eff;
    int i;
    int c;
    logic [DW-1:0] d;
    eff = (count > Depth) ? Depth : count;
    i = 0;
    c = 0;
    send_cmd(1'b1, base, count);
    if (eff == 0) begin
      @(negedge clk); bus.cmd_valid = 1'b0; #1;
      chk("load0_done", bus.done, 1);
      chk("load0_we", bus.mem_write_enable, 0);
      chk("load0_sready", bus.s_ready, 0);
      return;
    end
    while (i < eff) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      c++;
      if (c > 200) begin
        chk("load_timeout", i, eff);
        bus.s_valid = 1'b0;
        return;
      end
      bus.s_valid = gapped ? ((c % 3) != 0) : 1'b1;
      d = pattern ? DW'(32'h100 + i) : DW'($urandom);
      bus.s_data = d;
      #1;
      chk("s_ready", bus.s_ready, 1);
      chk("we_on_handshake", bus.mem_write_enable, bus.s_valid);
      chk("load_done_early", bus.done, 0);
      chk("load_m_valid", bus.m_valid, 0);
      if (bus.s_valid) begin
        chk("waddr", bus.mem_addr, (base + i) % Depth);
        chk("wdata", bus.mem_write_data, d);
        ref_mem[(base + i) % Depth] = d;
        i++;
      end
    end
    if (!gapped) chk("load_cycles", c, eff);
    @(negedge clk); bus.s_valid = 1'b0; #1;
    chk("load_done", bus.done, 1);
    chk("load_cmd_ready", bus.cmd_ready, 1);
    chk("load_we_after", bus.mem_write_enable, 0);
  endtask

  task automatic do_reset_pulse();
    @(negedge clk); rst = 1'b1; bus.m_ready = 1'b1; #1;
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_we", bus.mem_write_enable, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    @(negedge clk); rst = 1'b0; bus.m_ready = 1'b0; #1;
    chk("post_rst_m_valid", bus.m_valid, 0);
    chk("post_rst_cmd_ready", bus.cmd_ready, 1);
    chk("post_rst_done", bus.done, 0);
    @(negedge clk); #1;
    chk("post_rst_done2", bus.done, 0);
  endtask

  task automatic do_dump(input int base, input int count, input bit rnd, input int abort_after);
    int eff;
    int k;
    int c;
    bit hold;
    bit seen;
    logic [DW-1:0] held;
    eff = (count > Depth) ? Depth : count;
    k = 0;
    c = 0;
    hold = 1'b0;
    seen = 1'b0;
    held = '0;
    send_cmd(1'b0, base, count);
    if (eff == 0) begin
      @(negedge clk); bus.cmd_valid = 1'b0; bus.m_ready = 1'b1; #1;
      chk("dump0_done", bus.done, 1);
      chk("dump0_m_valid", bus.m_valid, 0);
      @(negedge clk); #1;
      chk("dump0_m_valid2", bus.m_valid, 0);
      bus.m_ready = 1'b0;
      return;
    end
    while (k < eff) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      c++;
      if (c > 300) begin
        chk("dump_timeout", k, eff);
        bus.m_ready = 1'b0;
        return;
      end
      bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("dump_we", bus.mem_write_enable, 0);
      chk("dump_done_early", bus.done, 0);
      if (hold) begin
        chk("hold_valid", bus.m_valid, 1);
        chk("hold_data", bus.m_data, held);
      end
      if (bus.m_valid) begin
        if (!seen) chk("first_valid_cycle", c, 3);
        seen = 1'b1;
        chk("m_data", bus.m_data, ref_mem[(base + k) % Depth]);
        chk("m_last", bus.m_last, (k == eff - 1));
        if (bus.m_ready) begin
          k++;
          hold = 1'b0;
          if (k == abort_after) break;
        end else begin
          hold = 1'b1;
          held = bus.m_data;
        end
      end else begin
        hold = 1'b0;
      end
    end
    if (abort_after != 0 && k == abort_after) begin
      do_reset_pulse();
      return;
    end
    if (!rnd) chk("last_word_cycle", c, eff + 2);
    @(negedge clk); bus.m_ready = 1'b0; #1;
    chk("dump_done", bus.done, 1);
    chk("dump_cmd_ready", bus.cmd_ready, 1);
    chk("dump_m_valid_after", bus.m_valid, 0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_count = '0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.m_ready   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("in_rst_we", bus.mem_write_enable, 0);
    chk("in_rst_s_ready", bus.s_ready, 0);
    chk("in_rst_m_valid", bus.m_valid, 0);
    chk("in_rst_done", bus.done, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_write_data, 0);
    chk("rst_mem_we", bus.mem_write_enable, 0);
    chk("rst_done", bus.done, 0);

    do_load(0, 16, 1'b0, 1'b1);
    do_dump(0, 16, 1'b0, 0);
    chk("pattern_word15", ref_mem[15], 32'h10F);
    do_load(14, 4, 1'b0, 1'b0);
    do_dump(14, 4, 1'b0, 0);
    do_dump(0, 16, 1'b1, 0);
    do_load(5, 0, 1'b0, 1'b0);
    do_dump(9, 0, 1'b0, 0);
    do_load(5, 9, 1'b1, 1'b0);
    do_dump(0, 16, 1'b1, 0);
    do_load(3, 20, 1'b0, 1'b0);
    do_dump(7, 31, 1'b0, 0);
    do_dump(0, 16, 1'b0, 5);
    do_dump(0, 16, 1'b0, 0);
    do_dump(2, 1, 1'b1, 0);
    do_dump(11, 7, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
